// File: rtl/ack_responder_pkg.sv
// Shared types and widths for the four-phase acknowledge responder.
package ack_responder_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  // Handshake progress: waiting for a request, counting down the delay, acknowledging.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10
  } state_t;

  // True when a request targets this responder.
  function automatic logic addr_match(input logic [ADDR_W-1:0] req_addr,
                                      input logic [ADDR_W-1:0] my_addr);
    return (req_addr == my_addr);
  endfunction

endpackage

// File: rtl/ack_delay_ctr.sv
// Down-counter that times the gap between request acceptance and acknowledge.
module ack_delay_ctr
  import ack_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Load on acceptance, otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ack_responder.sv
// Four-phase handshake responder: accepts an addressed request, acknowledges
// ACK_DELAY cycles later, reports payload, aborts and completed transfers.
module ack_responder
  import ack_responder_pkg::*;
#(
  parameter int unsigned ACK_DELAY = 2
)
(
  input  logic              CLK_IN,
  input  logic              RST_IN,
  input  logic              REQ_IN,
  input  logic [ADDR_W-1:0] MY_ADDR_IN,
  input  logic [ADDR_W-1:0] REQ_ADDR_IN,
  input  logic [DATA_W-1:0] REQ_DATA_IN,
  output logic              ACK_OUT,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_VALID_OUT,
  output logic              BUSY_OUT,
  output logic              ERR_OUT,
  output logic [7:0]        XFER_COUNT_OUT
);

  // The acceptance edge itself counts as the first delay cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACK_DELAY - 1);

  state_t            state_r;
  logic              armed_r;
  logic [DATA_W-1:0] cap_data_r;
  logic              ack_r;
  logic [DATA_W-1:0] data_r;
  logic              dv_r;
  logic              err_r;
  logic              busy_r;
  logic [7:0]        xfer_cnt_r;

  logic              accept_s;
  logic              ctr_dec_s;
  logic              ctr_zero_s;

  // Decode acceptance and counter stepping from the current state and request.
  always_comb begin
    accept_s  = 1'b0;
    ctr_dec_s = 1'b0;
    if ((state_r == IDLE) && armed_r && REQ_IN && addr_match(REQ_ADDR_IN, MY_ADDR_IN)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if ((state_r == WAIT) && REQ_IN && !ctr_zero_s) begin
      ctr_dec_s = 1'b1;
    end else begin
      ctr_dec_s = 1'b0;
    end
  end

  ack_delay_ctr u_delay_ctr (
    .clk      (CLK_IN),
    .rst      (RST_IN),
    .load     (accept_s),
    .load_val (LOAD_VAL),
    .dec      (ctr_dec_s),
    .zero     (ctr_zero_s)
  );

  // A request is only honoured once REQ_IN has been seen low since reset,
  // so a request left high across reset is never mistaken for a new one.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      armed_r <= 1'b0;
    end else if (!REQ_IN) begin
      armed_r <= 1'b1;
    end else begin
      armed_r <= armed_r;
    end
  end

  // Handshake state machine with registered outputs.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state_r    <= IDLE;
      cap_data_r <= {DATA_W{1'b0}};
      ack_r      <= 1'b0;
      data_r     <= {DATA_W{1'b0}};
      dv_r       <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      xfer_cnt_r <= 8'h00;
    end else begin
      dv_r  <= 1'b0;
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cap_data_r <= REQ_DATA_IN;
            state_r    <= WAIT;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= IDLE;
          end
        end
        WAIT: begin
          if (!REQ_IN) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            err_r   <= 1'b1;
          end else if (ctr_zero_s) begin
            state_r    <= ACK;
            ack_r      <= 1'b1;
            data_r     <= cap_data_r;
            dv_r       <= 1'b1;
            xfer_cnt_r <= xfer_cnt_r + 8'd1;
          end else begin
            state_r <= WAIT;
          end
        end
        ACK: begin
          if (!REQ_IN) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ACK;
          end
        end
        default: begin
          state_r <= IDLE;
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ACK_OUT        = ack_r;
  assign DATA_OUT       = data_r;
  assign DATA_VALID_OUT = dv_r;
  assign BUSY_OUT       = busy_r;
  assign ERR_OUT        = err_r;
  assign XFER_COUNT_OUT = xfer_cnt_r;

endmodule

// File: tb/tb_ack_responder.sv
// Bench for ack_responder: three instances (ACK_DELAY 2, 4, 1) share one
// stimulus stream and are checked every cycle against a timing model.
module tb_ack_responder;

  logic       CLK_IN = 1'b0;
  logic       RST_IN = 1'b1;
  logic       REQ_IN = 1'b0;
  logic [1:0] MY_ADDR_IN = 2'd1;
  logic [1:0] REQ_ADDR_IN = 2'd0;
  logic [7:0] REQ_DATA_IN = 8'h00;

  logic       ack_o  [3];
  logic [7:0] data_o [3];
  logic       dv_o   [3];
  logic       busy_o [3];
  logic       err_o  [3];
  logic [7:0] cnt_o  [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK_IN = ~CLK_IN;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ack_responder #(.ACK_DELAY(g == 0 ? 2 : (g == 1 ? 4 : 1))) u_dut (
      .CLK_IN         (CLK_IN),
      .RST_IN         (RST_IN),
      .REQ_IN         (REQ_IN),
      .MY_ADDR_IN     (MY_ADDR_IN),
      .REQ_ADDR_IN    (REQ_ADDR_IN),
      .REQ_DATA_IN    (REQ_DATA_IN),
      .ACK_OUT        (ack_o[g]),
      .DATA_OUT       (data_o[g]),
      .DATA_VALID_OUT (dv_o[g]),
      .BUSY_OUT       (busy_o[g]),
      .ERR_OUT        (err_o[g]),
      .XFER_COUNT_OUT (cnt_o[g])
    );
  end

  // Model: a transaction is "open" from acceptance; it acknowledges once it
  // has aged ACK_DELAY edges, and a request dropped before that is an abort.
  bit         m_armed  [3];
  bit         m_active [3];
  int         m_age    [3];
  logic [7:0] m_pay    [3];
  bit         e_ack    [3];
  logic [7:0] e_data   [3];
  bit         e_dv     [3];
  bit         e_err    [3];
  bit         e_busy   [3];
  logic [7:0] e_cnt    [3];

  function automatic int dly_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
  endfunction

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (RST_IN) begin
        m_armed[k] = 0; m_active[k] = 0; m_age[k] = 0; m_pay[k] = 8'h00;
        e_ack[k] = 0; e_data[k] = 8'h00; e_dv[k] = 0; e_err[k] = 0;
        e_busy[k] = 0; e_cnt[k] = 8'h00;
      end else begin
        e_dv[k]  = 0;
        e_err[k] = 0;
        if (m_active[k]) begin
          if (!REQ_IN) begin
            if (m_age[k] < dly_of(k)) e_err[k] = 1;
            m_active[k] = 0;
            e_ack[k]    = 0;
          end else begin
            m_age[k] = m_age[k] + 1;
            if (m_age[k] == dly_of(k)) begin
              e_ack[k]  = 1;
              e_data[k] = m_pay[k];
              e_dv[k]   = 1;
              e_cnt[k]  = e_cnt[k] + 8'd1;
            end
          end
        end else if (m_armed[k] && REQ_IN && (REQ_ADDR_IN == MY_ADDR_IN)) begin
          m_active[k] = 1;
          m_age[k]    = 0;
          m_pay[k]    = REQ_DATA_IN;
        end
        e_busy[k] = m_active[k];
        if (!REQ_IN) m_armed[k] = 1;
      end
    end
  endtask

  // One clock: advance the model at the edge, compare every output just after.
  task automatic tick();
    @(posedge CLK_IN);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("ack",  k, {7'd0, ack_o[k]},  {7'd0, e_ack[k]});
      chk("data", k, data_o[k],         e_data[k]);
      chk("dv",   k, {7'd0, dv_o[k]},   {7'd0, e_dv[k]});
      chk("busy", k, {7'd0, busy_o[k]}, {7'd0, e_busy[k]});
      chk("err",  k, {7'd0, err_o[k]},  {7'd0, e_err[k]});
      chk("cnt",  k, cnt_o[k],          e_cnt[k]);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    ticks(2);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ack", k, {7'd0, ack_o[k]}, 8'h00);
      chk("rst_data", k, data_o[k], 8'h00);
      chk("rst_cnt", k, cnt_o[k], 8'h00);
      chk("rst_busy", k, {7'd0, busy_o[k]}, 8'h00);
    end
    RST_IN = 1'b0;
    tick();

    // Basic handshake; address/data/my-address changes after acceptance ignored
    REQ_ADDR_IN = 2'd1; REQ_DATA_IN = 8'hA5; REQ_IN = 1'b1;
    tick();
    chk("a_busy", 0, {7'd0, busy_o[0]}, 8'h01);
    chk("a_ack_e0", 0, {7'd0, ack_o[0]}, 8'h00);
    REQ_ADDR_IN = 2'd2; REQ_DATA_IN = 8'h3C; MY_ADDR_IN = 2'd3;
    tick();
    chk("a_ack_e1", 0, {7'd0, ack_o[0]}, 8'h00);
    chk("a_ack_d1", 2, {7'd0, ack_o[2]}, 8'h01);
    tick();
    chk("a_ack_e2", 0, {7'd0, ack_o[0]}, 8'h01);
    chk("a_data", 0, data_o[0], 8'hA5);
    chk("a_dv", 0, {7'd0, dv_o[0]}, 8'h01);
    chk("a_cnt", 0, cnt_o[0], 8'h01);
    tick();
    chk("a_dv_once", 0, {7'd0, dv_o[0]}, 8'h00);
    tick();
    chk("a_ack_d4", 1, {7'd0, ack_o[1]}, 8'h01);
    chk("a_data_d4", 1, data_o[1], 8'hA5);
    REQ_IN = 1'b0; MY_ADDR_IN = 2'd1;
    tick();
    chk("a_ack_fall", 0, {7'd0, ack_o[0]}, 8'h00);

    // Address mismatch held for ten cycles
    REQ_ADDR_IN = 2'd2; REQ_IN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("b_ack", 0, {7'd0, ack_o[0]}, 8'h00);
      chk("b_busy", 0, {7'd0, busy_o[0]}, 8'h00);
    end
    REQ_IN = 1'b0;
    tick();

    // Abort on the 4-cycle instance: request dropped after edge 2
    REQ_ADDR_IN = 2'd1; REQ_DATA_IN = 8'h5A; REQ_IN = 1'b1;
    ticks(3);
    REQ_IN = 1'b0;
    tick();
    chk("c_err", 1, {7'd0, err_o[1]}, 8'h01);
    chk("c_ack", 1, {7'd0, ack_o[1]}, 8'h00);
    chk("c_cnt", 1, cnt_o[1], 8'h01);
    chk("c_data", 1, data_o[1], 8'hA5);
    chk("c_cnt_d2", 0, cnt_o[0], 8'h02);
    tick();
    chk("c_err_once", 1, {7'd0, err_o[1]}, 8'h00);

    // Reset while acknowledging, then request held through reset release
    REQ_DATA_IN = 8'h77; REQ_IN = 1'b1;
    ticks(5);
    chk("d_ack_pre", 1, {7'd0, ack_o[1]}, 8'h01);
    RST_IN = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("d_rst_ack", k, {7'd0, ack_o[k]}, 8'h00);
      chk("d_rst_data", k, data_o[k], 8'h00);
      chk("d_rst_cnt", k, cnt_o[k], 8'h00);
      chk("d_rst_err", k, {7'd0, err_o[k]}, 8'h00);
    end
    RST_IN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("d_held_ack", 2, {7'd0, ack_o[2]}, 8'h00);
      chk("d_held_busy", 0, {7'd0, busy_o[0]}, 8'h00);
    end
    REQ_IN = 1'b0;
    tick();
    REQ_IN = 1'b1;
    ticks(4);
    chk("d_re_ack_e3", 1, {7'd0, ack_o[1]}, 8'h00);
    tick();
    chk("d_re_ack_e4", 1, {7'd0, ack_o[1]}, 8'h01);
    chk("d_re_data", 1, data_o[1], 8'h77);
    REQ_IN = 1'b0;
    tick();

    // 256 back-to-back handshakes, counter wraps
    RST_IN = 1'b1;
    tick();
    RST_IN = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) begin
      REQ_ADDR_IN = 2'd1; REQ_DATA_IN = 8'(i); REQ_IN = 1'b1;
      ticks(5);
      if (i == 0) chk("e_first_cnt", 1, cnt_o[1], 8'h01);
      if (i == 254) chk("e_cnt_255", 1, cnt_o[1], 8'hFF);
      REQ_IN = 1'b0;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk("e_wrap_cnt", k, cnt_o[k], 8'h00);
      chk("e_last_data", k, data_o[k], 8'hFF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
